// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto a single pmem port.
// One transfer is outstanding at a time; simultaneous requests are granted
// round-robin.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transfer outstanding; sample requests and grant one
// SERVE_I | I-cache fill outstanding on pmem, waiting for pmem_resp
// SERVE_D | D-cache fill or writeback outstanding, waiting for pmem_resp
module cache_arbiter (
   input  logic         clk,
   input  logic         rst,
   input  logic         icache_read,
   input  logic [31:0]  icache_address,
   output logic [255:0] icache_rdata,
   output logic         icache_resp,
   input  logic         dcache_read,
   input  logic         dcache_write,
   input  logic [31:0]  dcache_address,
   input  logic [255:0] dcache_wdata,
   output logic [255:0] dcache_rdata,
   output logic         dcache_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

   state_t        state, state_next;
   logic          last_grant_d;   // 0: I-cache won last, 1: D-cache won last
   logic [31:0]   addr_q;
   logic          write_q;
   logic [255:0]  wdata_q;
   logic          grant_i, grant_d;
   logic          d_req;

   assign d_req = dcache_read | dcache_write;

   // Next-state and grant decision; ties go to whoever did not win last time.
   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      unique case (state)
         IDLE: begin
            if (icache_read && d_req) begin
               if (last_grant_d) grant_i = 1'b1;
               else              grant_d = 1'b1;
            end else if (icache_read) begin
               grant_i = 1'b1;
            end else if (d_req) begin
               grant_d = 1'b1;
            end
            if (grant_i)      state_next = SERVE_I;
            else if (grant_d) state_next = SERVE_D;
         end
         SERVE_I: if (pmem_resp) state_next = IDLE;
         SERVE_D: if (pmem_resp) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register plus holding registers loaded only at grant, so requester
   // inputs may change freely while a transfer is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         last_grant_d <= 1'b0;
         addr_q       <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
      end else begin
         state <= state_next;
         if (grant_i) begin
            addr_q       <= icache_address & LINE_MASK;
            write_q      <= 1'b0;
            last_grant_d <= 1'b0;
         end else if (grant_d) begin
            addr_q       <= dcache_address & LINE_MASK;
            write_q      <= dcache_write;   // read+write together is a writeback
            wdata_q      <= dcache_wdata;
            last_grant_d <= 1'b1;
         end
      end
   end

   // pmem request is a pure function of registered state.
   always_comb begin
      pmem_read    = (state != IDLE) && !write_q;
      pmem_write   = (state != IDLE) &&  write_q;
      pmem_address = addr_q;
      pmem_wdata   = wdata_q;
      icache_rdata = pmem_rdata;
      dcache_rdata = pmem_rdata;
      icache_resp  = (state == SERVE_I) && pmem_resp;
      dcache_resp  = (state == SERVE_D) && pmem_resp;
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: inputs driven on the falling edge,
// outputs checked on the falling edge (plus #1 for combinational resp paths).
module tb_cache_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         icache_read;
   logic [31:0]  icache_address;
   logic [255:0] icache_rdata;
   logic         icache_resp;
   logic         dcache_read, dcache_write;
   logic [31:0]  dcache_address;
   logic [255:0] dcache_wdata;
   logic [255:0] dcache_rdata;
   logic         dcache_resp;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   int errors = 0;
   int checks = 0;
   int iresp_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (icache_resp === 1'b1) iresp_cnt <= iresp_cnt + 1;

   cache_arbiter dut (
      .clk(clk), .rst(rst),
      .icache_read(icache_read), .icache_address(icache_address),
      .icache_rdata(icache_rdata), .icache_resp(icache_resp),
      .dcache_read(dcache_read), .dcache_write(dcache_write),
      .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
      .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      icache_read = 0; icache_address = '0;
      dcache_read = 0; dcache_write = 0; dcache_address = '0; dcache_wdata = '0;
      pmem_rdata = '0; pmem_resp = 0;
   endtask

   task automatic do_reset();
      rst = 1; clear_inputs();
      tick(); tick();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl got=%b exp=0000", {pmem_read, pmem_write, icache_resp, dcache_resp});
      end
      checks++;
      if (pmem_address !== 32'h0 || pmem_wdata !== 256'h0) begin
         errors++; $display("FAIL reset_hold addr=%h exp=0 wdata_nonzero=%b", pmem_address, |pmem_wdata);
      end
   endtask

   task automatic test_basic_read();
      logic [255:0] pat;
      pat = {8{32'hDEAD_BEEF}};
      icache_read = 1; icache_address = 32'h0000_1234;
      tick();
      checks++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h0000_1220) begin
         errors++; $display("FAIL basic_req rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=00001220", pmem_read, pmem_write, pmem_address);
      end
      pmem_resp = 1; pmem_rdata = pat; #1;
      checks++;
      if (icache_resp !== 1'b1 || dcache_resp !== 1'b0 || icache_rdata !== pat || dcache_rdata !== pat) begin
         errors++; $display("FAIL basic_resp iresp=%b dresp=%b exp iresp=1 dresp=0 rdata_ok=%b", icache_resp, dcache_resp, icache_rdata === pat);
      end
      tick();
      pmem_resp = 0; icache_read = 0; #1;
      checks++;
      if (pmem_read !== 1'b0 || icache_resp !== 1'b0) begin
         errors++; $display("FAIL basic_after rd=%b iresp=%b exp 0 0", pmem_read, icache_resp);
      end
      tick();
      checks++;
      if (pmem_read !== 1'b0) begin
         errors++; $display("FAIL basic_no_regrant rd=%b exp=0", pmem_read);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      icache_read = 1; icache_address = 32'h0000_0100;
      dcache_read = 1; dcache_address = 32'h0000_2200;
      tick();
      checks++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_2200) begin
         errors++; $display("FAIL rr_tie1 rd=%b addr=%h exp rd=1 addr=00002200", pmem_read, pmem_address);
      end
      pmem_resp = 1; #1;
      checks++;
      if (dcache_resp !== 1'b1 || icache_resp !== 1'b0) begin
         errors++; $display("FAIL rr_tie1_resp d=%b i=%b exp d=1 i=0", dcache_resp, icache_resp);
      end
      tick();
      pmem_resp = 0; dcache_read = 0;
      tick();
      checks++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0100) begin
         errors++; $display("FAIL rr_loser rd=%b addr=%h exp rd=1 addr=00000100", pmem_read, pmem_address);
      end
      pmem_resp = 1; #1;
      checks++;
      if (icache_resp !== 1'b1 || dcache_resp !== 1'b0) begin
         errors++; $display("FAIL rr_loser_resp i=%b d=%b exp i=1 d=0", icache_resp, dcache_resp);
      end
      tick();
      pmem_resp = 0; dcache_read = 1; dcache_address = 32'h0000_3300;
      tick();
      checks++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_3300) begin
         errors++; $display("FAIL rr_tie2 rd=%b addr=%h exp rd=1 addr=00003300", pmem_read, pmem_address);
      end
      pmem_resp = 1;
      tick();
      pmem_resp = 0; dcache_read = 0; icache_read = 0;
      tick(); tick();
   endtask

   task automatic test_write_hold();
      do_reset();
      dcache_write = 1; dcache_address = 32'h8000_0040; dcache_wdata = '1;
      tick();
      dcache_write = 0; dcache_read = 1; dcache_address = 32'h1111_1111; dcache_wdata = '0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h8000_0040 || pmem_wdata !== {256{1'b1}}) begin
            errors++; $display("FAIL wr_hold cyc=%0d wr=%b rd=%b addr=%h exp wr=1 rd=0 addr=80000040 wdata_ones=%b", i, pmem_write, pmem_read, pmem_address, &pmem_wdata);
         end
         tick();
      end
      pmem_resp = 1; #1;
      checks++;
      if (dcache_resp !== 1'b1) begin
         errors++; $display("FAIL wr_resp d=%b exp=1", dcache_resp);
      end
      tick();
      pmem_resp = 0; dcache_read = 0;
      dcache_read = 1; dcache_write = 1; dcache_address = 32'h0000_005F;
      tick();
      checks++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h0000_0040) begin
         errors++; $display("FAIL rw_as_write wr=%b rd=%b addr=%h exp wr=1 rd=0 addr=00000040", pmem_write, pmem_read, pmem_address);
      end
   endtask

   task automatic test_reset_mid();
      checks++;
      if (pmem_write !== 1'b1) begin
         errors++; $display("FAIL mid_pre wr=%b exp=1", pmem_write);
      end
      rst = 1;
      tick();
      rst = 0; clear_inputs(); #1;
      checks++;
      if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0 || pmem_address !== 32'h0 || pmem_wdata !== 256'h0) begin
         errors++; $display("FAIL mid_reset ctrl=%b addr=%h exp ctrl=0000 addr=0", {pmem_read, pmem_write, icache_resp, dcache_resp}, pmem_address);
      end
      pmem_resp = 1; #1;
      checks++;
      if (icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
         errors++; $display("FAIL mid_late_resp i=%b d=%b exp 0 0", icache_resp, dcache_resp);
      end
      tick();
      pmem_resp = 0;
   endtask

   task automatic test_long_wait();
      int base;
      do_reset();
      base = iresp_cnt;
      icache_read = 1; icache_address = 32'h0000_4444;
      tick();
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (pmem_read !== 1'b1 || icache_resp !== 1'b0) begin
            errors++; $display("FAIL long_hold cyc=%0d rd=%b iresp=%b exp rd=1 iresp=0", i, pmem_read, icache_resp);
         end
         tick();
      end
      pmem_resp = 1;
      tick();
      pmem_resp = 0; icache_read = 0; #1;
      checks++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
         errors++; $display("FAIL long_after rd=%b wr=%b exp 0 0", pmem_read, pmem_write);
      end
      tick(); tick();
      checks++;
      if (iresp_cnt - base !== 1) begin
         errors++; $display("FAIL long_pulses got=%0d exp=1", iresp_cnt - base);
      end
   endtask

   task automatic test_stray_resp();
      pmem_resp = 1; pmem_rdata = {8{32'h1234_5678}}; #1;
      checks++;
      if (icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
         errors++; $display("FAIL stray_resp i=%b d=%b exp 0 0", icache_resp, dcache_resp);
      end
      tick();
      checks++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
         errors++; $display("FAIL stray_state rd=%b wr=%b i=%b d=%b exp all 0", pmem_read, pmem_write, icache_resp, dcache_resp);
      end
      pmem_resp = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_round_robin();
      test_write_hold();
      test_reset_mid();
      test_long_wait();
      test_stray_resp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 icache_read  input  1  I-cache line-fill request.
REQ-005 icache_address  input  32  I-cache line address.
REQ-006 icache_rdata  output  256  line data to I-cache.
REQ-007 icache_resp  output  1  one-cycle completion pulse to I-cache.
REQ-008 dcache_read, dcache_write  input  1 each  D-cache line fill / writeback request.
REQ-009 dcache_address  input  32  D-cache line address.
REQ-010 dcache_wdata  input  256  D-cache writeback line.
REQ-011 dcache_rdata  output  256  line data to D-cache.
REQ-012 dcache_resp  output  1  one-cycle completion pulse to D-cache.
REQ-013 pmem_read, pmem_write  output  1 each  request to the cacheline adaptor.
REQ-014 pmem_address  output  32  line address to the adaptor, bits [4:0] forced to 0.
REQ-015 pmem_wdata  output  256  writeback line to the adaptor.
REQ-016 pmem_rdata  input  256  fill line from the adaptor.
REQ-017 pmem_resp  input  1  adaptor completion pulse.

Function
REQ-018 FSM states: IDLE, SERVE_I, SERVE_D; one request outstanding on the pmem port at a time.
REQ-019 IDLE: icache_read only -> SERVE_I; dcache_read or dcache_write only -> SERVE_D; neither -> stay in IDLE.
REQ-020 IDLE, both pending: grant the requester not recorded in last_grant (round-robin); then update last_grant to the winner.
REQ-021 On grant, capture the winner's address (bits [4:0] cleared), op (read/write) and wdata into holding registers; later changes on the requester inputs are ignored until completion.
REQ-022 dcache_read and dcache_write asserted together count as a write.
REQ-023 Grant latency: request sampled in IDLE at edge N; pmem_read/pmem_write asserted from cycle N+1, driven from registered state only.
REQ-024 pmem_read/pmem_write stay asserted continuously in SERVE_x until pmem_resp.
REQ-025 Cycle with pmem_resp in SERVE_x: assert x_resp in the same cycle; x_rdata = pmem_rdata combinationally; next state IDLE.
REQ-026 icache_rdata and dcache_rdata always equal pmem_rdata; only the resp pulses are gated per requester.
REQ-027 The non-granted resp stays 0; in IDLE both resps stay 0 and pmem_resp is ignored.
REQ-028 At least one IDLE cycle follows every completion, so a requester deasserting after its resp is never re-granted.
REQ-029 Requests are never dropped: a pending loser is granted on the next IDLE.

Reset
REQ-030 rst asserted in any state, including mid-transfer: next state IDLE.
REQ-031 Reset values: pmem_read=0, pmem_write=0, icache_resp=0, dcache_resp=0.
REQ-032 Reset values, continued: holding registers=0, so pmem_address=0 and pmem_wdata=0.
REQ-033 Reset value of last_grant = I, so the first tie goes to the D-cache.
REQ-034 A pmem_resp arriving after reset is ignored.

Verification
REQ-035 Reset, then icache_read at addr 0x0000_1234 -> next cycle pmem_read=1, pmem_address=0x0000_1220; pmem_resp with rdata=X -> icache_resp=1 and icache_rdata=X in the same cycle.
REQ-036 After reset, icache_read and dcache_read at the same edge -> D served first; I granted on the following IDLE; then a second tie -> D served.
REQ-037 dcache_write at 0x8000_0040 with wdata=all-ones, input changed one cycle after grant -> pmem_write=1, pmem_wdata=all-ones, address 0x8000_0040 until pmem_resp.
REQ-038 rst asserted while in SERVE_D with pmem_write=1 -> next cycle all outputs 0; a late pmem_resp produces no resp pulse.
REQ-039 pmem_resp delayed 20 cycles -> pmem_read held for all 20 cycles; exactly one resp pulse; no pmem request in the cycle after completion.
REQ-040 Stray pmem_resp in IDLE -> no state change and no resp pulse.
